add_comp_slt: RTL and testbench

Add-compare-select (ACS) unit for a 4-state (constraint length K=3, rate-1/2) hard-decision Viterbi decoder. Each enabled cycle it adds eight 2-bit branch Hamming distances to four internally held path metrics and keeps the survivor branch into each state. It outputs the chosen predecessor of every state and the current best (minimum-metric) state. It sits between the branch-metric unit and the survivor-memory/traceback unit.

---
 rtl/add_comp_slt_pkg.sv | 23 ++
 rtl/add_comp_slt_acs_cell.sv | 25 ++
 rtl/add_comp_slt.sv | 120 ++++++++++++
 tb/tb_add_comp_slt.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_comp_slt_pkg.sv
// Shared constants and types for the 4-state Viterbi add-compare-select unit.
package add_comp_slt_pkg;

    // Path-metric width and the reset bias for the non-zero start states
    localparam int unsigned PM_W          = 8;
    localparam int unsigned HD_W          = 2;
    localparam int unsigned PM_INIT_OTHER = 16;

    // State codes are the encoder shift-register contents
    localparam logic [1:0] ST00 = 2'b00;
    localparam logic [1:0] ST10 = 2'b10;
    localparam logic [1:0] ST01 = 2'b01;
    localparam logic [1:0] ST11 = 2'b11;

    typedef logic [PM_W-1:0] pm_t;
    typedef logic [HD_W-1:0] hd_t;

    // Zero-extend a branch distance to path-metric width
    function automatic pm_t hd_ext(input hd_t hd);
        return pm_t'(hd);
    endfunction

endpackage

// File: rtl/add_comp_slt_acs_cell.sv
// One add-compare-select cell: two candidate path extensions, keep the smaller.
// A tie keeps the first candidate (sel=0).
module add_comp_slt_acs_cell
    import add_comp_slt_pkg::*;
(
    input  logic [PM_W-1:0] pm_a,
    input  logic [HD_W-1:0] hd_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [HD_W-1:0] hd_b,
    output logic [PM_W-1:0] sum,
    output logic            sel
);

    pm_t cand_a;
    pm_t cand_b;

    // Add both branches, choose the strictly smaller second candidate only
    always_comb begin
        cand_a = pm_a + hd_ext(hd_a);
        cand_b = pm_b + hd_ext(hd_b);
        sel    = (cand_b < cand_a);
        sum    = sel ? cand_b : cand_a;
    end

endmodule

// File: rtl/add_comp_slt.sv
// Add-compare-select unit for a K=3 rate-1/2 hard-decision Viterbi decoder.
// Holds four normalized path metrics, emits survivor predecessors and the
// best state, all registered together with one cycle of latency.
module add_comp_slt
    import add_comp_slt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_acs,
    input  logic [1:0] hd1,
    input  logic [1:0] hd2,
    input  logic [1:0] hd3,
    input  logic [1:0] hd4,
    input  logic [1:0] hd5,
    input  logic [1:0] hd6,
    input  logic [1:0] hd7,
    input  logic [1:0] hd8,
    output logic [1:0] o_prev_st_00,
    output logic [1:0] o_prev_st_10,
    output logic [1:0] o_prev_st_01,
    output logic [1:0] o_prev_st_11,
    output logic [1:0] o_slt_node
);

    // Stored metrics, indexed by state code
    pm_t pm_q [4];

    pm_t  sum_00, sum_10, sum_01, sum_11;
    logic sel_00, sel_10, sel_01, sel_11;

    pm_t        min_lo, min_hi, min_all;
    logic [1:0] idx_lo, idx_hi, slt_d;
    pm_t        pm_d   [4];
    logic [1:0] prev_d [4];

    // States 00 and 10 are reached from 00 (first) or 01
    add_comp_slt_acs_cell u_acs_00 (
        .pm_a (pm_q[ST00]), .hd_a (hd1),
        .pm_b (pm_q[ST01]), .hd_b (hd2),
        .sum  (sum_00),     .sel  (sel_00)
    );

    add_comp_slt_acs_cell u_acs_10 (
        .pm_a (pm_q[ST00]), .hd_a (hd3),
        .pm_b (pm_q[ST01]), .hd_b (hd4),
        .sum  (sum_10),     .sel  (sel_10)
    );

    // States 01 and 11 are reached from 10 (first) or 11
    add_comp_slt_acs_cell u_acs_01 (
        .pm_a (pm_q[ST10]), .hd_a (hd5),
        .pm_b (pm_q[ST11]), .hd_b (hd6),
        .sum  (sum_01),     .sel  (sel_01)
    );

    add_comp_slt_acs_cell u_acs_11 (
        .pm_a (pm_q[ST10]), .hd_a (hd7),
        .pm_b (pm_q[ST11]), .hd_b (hd8),
        .sum  (sum_11),     .sel  (sel_11)
    );

    // Min-of-4 with priority 00,10,01,11; then normalize and map selects to state codes
    always_comb begin
        // Pairing (00,10) and (01,11) keeps the priority order: ties fall to the lower pair
        min_lo = sum_00;
        idx_lo = ST00;
        if (sum_10 < sum_00) begin
            min_lo = sum_10;
            idx_lo = ST10;
        end
        min_hi = sum_01;
        idx_hi = ST01;
        if (sum_11 < sum_01) begin
            min_hi = sum_11;
            idx_hi = ST11;
        end
        min_all = min_lo;
        slt_d   = idx_lo;
        if (min_hi < min_lo) begin
            min_all = min_hi;
            slt_d   = idx_hi;
        end

        pm_d[ST00] = sum_00 - min_all;
        pm_d[ST10] = sum_10 - min_all;
        pm_d[ST01] = sum_01 - min_all;
        pm_d[ST11] = sum_11 - min_all;

        prev_d[ST00] = sel_00 ? ST01 : ST00;
        prev_d[ST10] = sel_10 ? ST01 : ST00;
        prev_d[ST01] = sel_01 ? ST11 : ST10;
        prev_d[ST11] = sel_11 ? ST11 : ST10;
    end

    // Metric and output registers; reset biases the trellis toward state 00
    always_ff @(posedge clk) begin
        if (!rst) begin
            pm_q[ST00]   <= '0;
            pm_q[ST10]   <= pm_t'(PM_INIT_OTHER);
            pm_q[ST01]   <= pm_t'(PM_INIT_OTHER);
            pm_q[ST11]   <= pm_t'(PM_INIT_OTHER);
            o_prev_st_00 <= ST00;
            o_prev_st_10 <= ST00;
            o_prev_st_01 <= ST00;
            o_prev_st_11 <= ST00;
            o_slt_node   <= ST00;
        end else if (en_acs) begin
            pm_q[ST00]   <= pm_d[ST00];
            pm_q[ST10]   <= pm_d[ST10];
            pm_q[ST01]   <= pm_d[ST01];
            pm_q[ST11]   <= pm_d[ST11];
            o_prev_st_00 <= prev_d[ST00];
            o_prev_st_10 <= prev_d[ST10];
            o_prev_st_01 <= prev_d[ST01];
            o_prev_st_11 <= prev_d[ST11];
            o_slt_node   <= slt_d;
        end
    end

endmodule

// File: tb/tb_add_comp_slt.sv
// Self-checking bench for add_comp_slt: directed trellis sequences plus a
// randomized run against a transition-table reference model.
module tb_add_comp_slt;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_acs = 1'b0;
    logic [1:0] hd1 = '0, hd2 = '0, hd3 = '0, hd4 = '0;
    logic [1:0] hd5 = '0, hd6 = '0, hd7 = '0, hd8 = '0;
    logic [1:0] o_prev_st_00, o_prev_st_10, o_prev_st_01, o_prev_st_11;
    logic [1:0] o_slt_node;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: metrics, predecessors and best state indexed by state code value
    int m_pm   [4];
    int m_prev [4];
    int m_slt;
    int hdv    [1:8];

    add_comp_slt dut (
        .clk          (clk),
        .rst          (rst),
        .en_acs       (en_acs),
        .hd1          (hd1),
        .hd2          (hd2),
        .hd3          (hd3),
        .hd4          (hd4),
        .hd5          (hd5),
        .hd6          (hd6),
        .hd7          (hd7),
        .hd8          (hd8),
        .o_prev_st_00 (o_prev_st_00),
        .o_prev_st_10 (o_prev_st_10),
        .o_prev_st_01 (o_prev_st_01),
        .o_prev_st_11 (o_prev_st_11),
        .o_slt_node   (o_slt_node)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Which hd input labels the branch from state p to state s (-1: no such branch)
    function automatic int branch_hd(input int p, input int s);
        case ({p[1:0], s[1:0]})
            4'b00_00: return 1;
            4'b01_00: return 2;
            4'b00_10: return 3;
            4'b01_10: return 4;
            4'b10_01: return 5;
            4'b11_01: return 6;
            4'b10_11: return 7;
            4'b11_11: return 8;
            default:  return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_pm[0] = 0;
        m_pm[1] = 16;
        m_pm[2] = 16;
        m_pm[3] = 16;
        for (int i = 0; i < 4; i++) m_prev[i] = 0;
        m_slt = 0;
    endtask

    // One trellis step: each old state p with input bit b goes to {b, p[1]}
    task automatic model_step();
        int nxt [4];
        int order [4];
        int best;
        for (int s = 0; s < 4; s++) nxt[s] = 1 << 20;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 2; b++) begin
                int s;
                int c;
                s = b * 2 + (p >> 1);
                c = m_pm[p] + hdv[branch_hd(p, s)];
                // Lower-numbered predecessor is the first-listed one, so strict < keeps it on ties
                if (c < nxt[s]) begin
                    nxt[s]    = c;
                    m_prev[s] = p;
                end
            end
        end
        order[0] = 0; order[1] = 2; order[2] = 1; order[3] = 3;
        best = order[0];
        for (int k = 1; k < 4; k++)
            if (nxt[order[k]] < nxt[best]) best = order[k];
        m_slt = best;
        for (int s = 0; s < 4; s++) m_pm[s] = nxt[s] - nxt[best];
    endtask

    // Drive one cycle, let the edge pass, then advance the model
    task automatic tick(input logic r, input logic e);
        rst    = r;
        en_acs = e;
        hd1 = hdv[1][1:0]; hd2 = hdv[2][1:0]; hd3 = hdv[3][1:0]; hd4 = hdv[4][1:0];
        hd5 = hdv[5][1:0]; hd6 = hdv[6][1:0]; hd7 = hdv[7][1:0]; hd8 = hdv[8][1:0];
        @(posedge clk);
        #1;
        if (!r) model_reset();
        else if (e) model_step();
    endtask

    task automatic set_hd(input int a, b, c, d, e, f, g, h);
        hdv[1] = a; hdv[2] = b; hdv[3] = c; hdv[4] = d;
        hdv[5] = e; hdv[6] = f; hdv[7] = g; hdv[8] = h;
    endtask

    task automatic rand_hd();
        for (int i = 1; i <= 8; i++) hdv[i] = int'($urandom_range(3, 0));
    endtask

    // Compare every output and stored metric with the model
    task automatic check_model(input string tag);
        int mx;
        int mn;
        check_val({tag, ".prev00"}, int'(o_prev_st_00), m_prev[0]);
        check_val({tag, ".prev10"}, int'(o_prev_st_10), m_prev[2]);
        check_val({tag, ".prev01"}, int'(o_prev_st_01), m_prev[1]);
        check_val({tag, ".prev11"}, int'(o_prev_st_11), m_prev[3]);
        check_val({tag, ".slt"},    int'(o_slt_node),   m_slt);
        check_val({tag, ".pm00"}, int'(dut.pm_q[0]), m_pm[0]);
        check_val({tag, ".pm01"}, int'(dut.pm_q[1]), m_pm[1]);
        check_val({tag, ".pm10"}, int'(dut.pm_q[2]), m_pm[2]);
        check_val({tag, ".pm11"}, int'(dut.pm_q[3]), m_pm[3]);
        mx = int'(dut.pm_q[0]);
        mn = int'(dut.pm_q[0]);
        for (int i = 1; i < 4; i++) begin
            if (int'(dut.pm_q[i]) > mx) mx = int'(dut.pm_q[i]);
            if (int'(dut.pm_q[i]) < mn) mn = int'(dut.pm_q[i]);
        end
        check_val({tag, ".pm_le19"}, int'(mx <= 19), 1);
        check_val({tag, ".pm_min0"}, mn, 0);
    endtask

    // Compare outputs with literal values (prev for states 00,10,01,11, then slt)
    task automatic expect_out(input string tag, input int p00, p10, p01, p11, slt);
        check_val({tag, ".prev00"}, int'(o_prev_st_00), p00);
        check_val({tag, ".prev10"}, int'(o_prev_st_10), p10);
        check_val({tag, ".prev01"}, int'(o_prev_st_01), p01);
        check_val({tag, ".prev11"}, int'(o_prev_st_11), p11);
        check_val({tag, ".slt"},    int'(o_slt_node),   slt);
    endtask

    initial begin
        model_reset();
        set_hd(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset for two edges, then idle with random distances
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        expect_out("reset", 0, 0, 0, 0, 0);
        check_val("reset.pm00", int'(dut.pm_q[0]), 0);
        check_val("reset.pm10", int'(dut.pm_q[2]), 16);
        for (int i = 0; i < 3; i++) begin
            rand_hd();
            tick(1'b1, 1'b0);
            expect_out("idle", 0, 0, 0, 0, 0);
        end

        // Constant-distance run from the reset metrics
        set_hd(2, 3, 1, 2, 2, 1, 3, 0);
        tick(1'b1, 1'b1);
        expect_out("const.e1", 0, 0, 3, 3, 2);
        check_val("const.e1.pm00", int'(dut.pm_q[0]), 1);
        check_val("const.e1.pm10", int'(dut.pm_q[2]), 0);
        check_val("const.e1.pm01", int'(dut.pm_q[1]), 16);
        check_val("const.e1.pm11", int'(dut.pm_q[3]), 15);
        tick(1'b1, 1'b1);
        expect_out("const.e2", 0, 0, 2, 2, 2);
        tick(1'b1, 1'b1);
        expect_out("const.e3", 0, 0, 2, 3, 3);
        tick(1'b1, 1'b1);
        expect_out("const.e4", 0, 0, 3, 3, 3);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1);
            expect_out("const.steady", 1, 1, 3, 3, 3);
            check_model("const.model");
        end

        // Enable low with changing distances: everything frozen
        for (int i = 0; i < 4; i++) begin
            rand_hd();
            tick(1'b1, 1'b0);
            expect_out("hold", 1, 1, 3, 3, 3);
            check_model("hold.model");
        end

        // Resume from held metrics
        set_hd(2, 3, 1, 2, 2, 1, 3, 0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b1);
            expect_out("resume", 1, 1, 3, 3, 3);
        end

        // Reset mid-run overrides enable, then the trellis restarts
        tick(1'b0, 1'b1);
        expect_out("midrst", 0, 0, 0, 0, 0);
        check_model("midrst.model");
        tick(1'b1, 1'b1);
        expect_out("midrst.e1", 0, 0, 3, 3, 2);

        // All-zero distances from reset
        tick(1'b0, 1'b0);
        set_hd(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1);
            expect_out("zero", 0, 0, 2, 2, 0);
            check_model("zero.model");
        end

        // Randomized stress with occasional enable drops and resets
        tick(1'b0, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            logic r;
            logic e;
            rand_hd();
            r = ($urandom_range(511, 0) != 0);
            e = ($urandom_range(7, 0) != 0);
            tick(r, e);
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
